// File: rtl/clock_pkg.sv
// Shared digit indices, BCD ranges and time-advance helpers for the DE2 clock.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t hr_t;
    bcd_t hr_u;
    bcd_t min_t;
    bcd_t min_u;
    bcd_t sec_t;
    bcd_t sec_u;
  } time_t;

  localparam logic [3:0] DIG_SEC_U = 4'd0;
  localparam logic [3:0] DIG_SEC_T = 4'd1;
  localparam logic [3:0] DIG_MIN_U = 4'd2;
  localparam logic [3:0] DIG_MIN_T = 4'd3;
  localparam logic [3:0] DIG_HR_U  = 4'd4;
  localparam logic [3:0] DIG_HR_T  = 4'd5;

  localparam bcd_t MAX_UNITS   = 4'd9;
  localparam bcd_t MAX_TENS    = 4'd5;
  localparam bcd_t MAX_HR_T    = 4'd2;
  localparam bcd_t MAX_HR_U_24 = 4'd3;

  // Out-of-range values also wrap to 0 so a corrupted digit self-heals.
  function automatic bcd_t bcd_inc(input bcd_t d, input bcd_t max);
    bcd_t r;
    r = (d >= max) ? '0 : bcd_t'(d + 4'd1);
    return r;
  endfunction

  function automatic time_t advance_time(input time_t t);
    time_t r;
    logic  c;
    r       = t;
    r.sec_u = bcd_inc(t.sec_u, MAX_UNITS);
    c       = (t.sec_u >= MAX_UNITS);
    if (c) begin
      r.sec_t = bcd_inc(t.sec_t, MAX_TENS);
      c       = (t.sec_t >= MAX_TENS);
    end
    if (c) begin
      r.min_u = bcd_inc(t.min_u, MAX_UNITS);
      c       = (t.min_u >= MAX_UNITS);
    end
    if (c) begin
      r.min_t = bcd_inc(t.min_t, MAX_TENS);
      c       = (t.min_t >= MAX_TENS);
    end
    if (c) begin
      if (t.hr_t >= MAX_HR_T && t.hr_u >= MAX_HR_U_24) begin
        r.hr_t = '0;
        r.hr_u = '0;
      end else if (t.hr_u >= MAX_UNITS) begin
        r.hr_u = '0;
        r.hr_t = bcd_t'(t.hr_t + 4'd1);
      end else begin
        r.hr_u = bcd_t'(t.hr_u + 4'd1);
      end
    end
    return r;
  endfunction

  function automatic logic [5:0] sel_mask(input logic [3:0] sel);
    logic [5:0] m;
    m = '0;
    if (sel <= DIG_HR_T) m[sel[2:0]] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/time_core_tick_gen.sv
// Modulo-N prescaler with enable and synchronous clear; tc flags the terminal count.
module tick_gen #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  assign tc = en & ~clr & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/time_core.sv
// HH:MM:SS BCD timekeeper with run/edit modes for the DE2 clock.
// Optional blink mask on the selected digit when TIME_CORE_BLINK_EN is defined.
module time_core
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned BLINK_DIV = 12_500_000
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        adjust,
  input  logic [3:0]  select,
  input  logic        add,
  input  logic        clr,
  output logic [23:0] time_bcd,
  output logic        tick,
  output logic [5:0]  blank
);

  time_t cur_q, cur_d;
  logic  add_q;
  logic  add_edge;
  logic  sec_tc;
  logic  edit_mode;

  assign edit_mode = ~adjust;
  assign add_edge  = add & ~add_q;

  // Held at zero in edit mode, so leaving edit restarts a full period.
  tick_gen #(.N(TICK_DIV)) u_sec_tick (
    .clk (CLOCK_50),
    .rst (rst),
    .en  (adjust),
    .clr (edit_mode),
    .tc  (sec_tc)
  );

  always_comb begin
    cur_d = cur_q;
    if (adjust) begin
      if (sec_tc) cur_d = advance_time(cur_q);
    end else if (clr) begin
      // clr outranks add; the edge is still absorbed by add_q.
      case (select)
        DIG_SEC_U: cur_d.sec_u = '0;
        DIG_SEC_T: cur_d.sec_t = '0;
        DIG_MIN_U: cur_d.min_u = '0;
        DIG_MIN_T: cur_d.min_t = '0;
        DIG_HR_U:  cur_d.hr_u  = '0;
        DIG_HR_T:  cur_d.hr_t  = '0;
        default: ;
      endcase
    end else if (add_edge) begin
      case (select)
        DIG_SEC_U: cur_d.sec_u = bcd_inc(cur_q.sec_u, MAX_UNITS);
        DIG_SEC_T: cur_d.sec_t = bcd_inc(cur_q.sec_t, MAX_TENS);
        DIG_MIN_U: cur_d.min_u = bcd_inc(cur_q.min_u, MAX_UNITS);
        DIG_MIN_T: cur_d.min_t = bcd_inc(cur_q.min_t, MAX_TENS);
        DIG_HR_U:  cur_d.hr_u  = bcd_inc(cur_q.hr_u,
                                   (cur_q.hr_t == MAX_HR_T) ? MAX_HR_U_24 : MAX_UNITS);
        DIG_HR_T: begin
          cur_d.hr_t = bcd_inc(cur_q.hr_t, MAX_HR_T);
          if (cur_d.hr_t == MAX_HR_T && cur_q.hr_u > MAX_HR_U_24) cur_d.hr_u = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      cur_q <= '0;
      add_q <= 1'b0;
      tick  <= 1'b0;
    end else begin
      cur_q <= cur_d;
      add_q <= add;
      tick  <= sec_tc;
    end
  end

  assign time_bcd = cur_q;

`ifdef TIME_CORE_BLINK_EN
  logic       blink_tc;
  logic       phase_q, phase_d;
  logic [5:0] blank_q;

  tick_gen #(.N(BLINK_DIV)) u_blink_tick (
    .clk (CLOCK_50),
    .rst (rst),
    .en  (edit_mode),
    .clr (adjust),
    .tc  (blink_tc)
  );

  always_comb begin
    phase_d = adjust ? 1'b0 : (phase_q ^ blink_tc);
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      phase_q <= 1'b0;
      blank_q <= '0;
    end else begin
      phase_q <= phase_d;
      blank_q <= sel_mask(select) & {6{phase_d}};
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_time_core.sv
// Directed bench for time_core: reset, count-up, edits, wrap, mode exit, reset mid-edit, blink.
module tb_time_core;

  logic        CLOCK_50 = 1'b0;
  logic        rst = 1'b1;
  logic        adjust = 1'b1;
  logic [3:0]  select = '0;
  logic        add = 1'b0;
  logic        clr = 1'b0;
  logic [23:0] time_bcd;
  logic        tick;
  logic [5:0]  blank;

  int unsigned checks = 0;
  int unsigned errors = 0;

  time_core #(.TICK_DIV(4), .BLINK_DIV(2)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .adjust   (adjust),
    .select   (select),
    .add      (add),
    .clr      (clr),
    .time_bcd (time_bcd),
    .tick     (tick),
    .blank    (blank)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [3:0]  sel;
    logic        add;
    logic        clr;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] s, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      select = s;
      add = 1'b1;
      step();
      add = 1'b0;
      step();
    end
  endtask

  initial begin
    logic [3:0] hu_exp [4];
    hu_exp = '{4'd1, 4'd2, 4'd3, 4'd0};

    // Edit-mode vectors, one cycle each, starting from 00:00:00 with add low.
    tbl.push_back('{4'd0, 1'b1, 1'b0, 24'h000001});
    tbl.push_back('{4'd0, 1'b0, 1'b0, 24'h000001});
    tbl.push_back('{4'd2, 1'b1, 1'b0, 24'h000101});
    tbl.push_back('{4'd2, 1'b0, 1'b0, 24'h000101});
    for (int i = 0; i < 10; i++) tbl.push_back('{4'd1, 1'b1, 1'b0, 24'h000111});
    tbl.push_back('{4'd1, 1'b0, 1'b0, 24'h000111});
    tbl.push_back('{4'd1, 1'b1, 1'b0, 24'h000121});
    tbl.push_back('{4'd1, 1'b0, 1'b0, 24'h000121});
    tbl.push_back('{4'd1, 1'b1, 1'b0, 24'h000131});
    tbl.push_back('{4'd1, 1'b0, 1'b0, 24'h000131});
    tbl.push_back('{4'd1, 1'b1, 1'b0, 24'h000141});
    tbl.push_back('{4'd1, 1'b0, 1'b0, 24'h000141});
    tbl.push_back('{4'd1, 1'b1, 1'b0, 24'h000151});
    tbl.push_back('{4'd1, 1'b0, 1'b0, 24'h000151});
    tbl.push_back('{4'd1, 1'b1, 1'b0, 24'h000101});
    tbl.push_back('{4'd1, 1'b0, 1'b0, 24'h000101});
    tbl.push_back('{4'd2, 1'b1, 1'b0, 24'h000201});
    tbl.push_back('{4'd2, 1'b0, 1'b0, 24'h000201});
    tbl.push_back('{4'd2, 1'b1, 1'b0, 24'h000301});
    tbl.push_back('{4'd2, 1'b0, 1'b0, 24'h000301});
    tbl.push_back('{4'd2, 1'b1, 1'b0, 24'h000401});
    tbl.push_back('{4'd2, 1'b0, 1'b0, 24'h000401});
    tbl.push_back('{4'd2, 1'b1, 1'b1, 24'h000001});
    tbl.push_back('{4'd2, 1'b1, 1'b0, 24'h000001});
    tbl.push_back('{4'd2, 1'b0, 1'b0, 24'h000001});
    tbl.push_back('{4'd9, 1'b1, 1'b0, 24'h000001});
    tbl.push_back('{4'd9, 1'b0, 1'b1, 24'h000001});
    tbl.push_back('{4'd6, 1'b0, 1'b0, 24'h000001});
    tbl.push_back('{4'd15, 1'b1, 1'b0, 24'h000001});
    tbl.push_back('{4'd15, 1'b0, 1'b0, 24'h000001});
    tbl.push_back('{4'd0, 1'b0, 1'b1, 24'h000000});

    // Reset state and count-up.
    step();
    step();
    check("rst_time", time_bcd, 24'h0);
    check("rst_tick", {23'd0, tick}, 24'd1 & 24'd0);
    check("rst_blank", {18'd0, blank}, 24'h0);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("count_tick_c%0d", c), {23'd0, tick}, (c % 4 == 0) ? 24'd1 : 24'd0);
      check($sformatf("count_time_c%0d", c), time_bcd, 24'(c / 4));
    end

    // Table-driven edit-mode vectors.
    rst = 1'b1;
    adjust = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("edit_start", time_bcd, 24'h0);
    for (int i = 0; i < tbl.size(); i++) begin
      select = tbl[i].sel;
      add = tbl[i].add;
      clr = tbl[i].clr;
      step();
      check($sformatf("vec%0d", i), time_bcd, tbl[i].exp);
      if (tick !== 1'b0) check($sformatf("vec%0d_tick", i), {23'd0, tick}, 24'd0);
    end
    add = 1'b0;
    clr = 1'b0;
    step();

    // Hour clamp and hr_u range at hr_t = 2.
    pulse(4'd5, 1);
    pulse(4'd4, 7);
    check("hr_preload", time_bcd, 24'h170000);
    pulse(4'd5, 1);
    check("hr_clamp", time_bcd, 24'h200000);
    for (int i = 0; i < 4; i++) begin
      pulse(4'd4, 1);
      check($sformatf("hr_u_step%0d", i), time_bcd, {4'h2, hu_exp[i], 16'h0});
    end
    pulse(4'd5, 1);
    check("hr_t_wrap", time_bcd, 24'h000000);

    // Full wrap from 23:59:59.
    pulse(4'd5, 2);
    pulse(4'd4, 3);
    pulse(4'd3, 5);
    pulse(4'd2, 9);
    pulse(4'd1, 5);
    pulse(4'd0, 9);
    check("wrap_preload", time_bcd, 24'h235959);
    adjust = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("wrap_tick_c%0d", c), {23'd0, tick}, (c == 4) ? 24'd1 : 24'd0);
      check($sformatf("wrap_time_c%0d", c), time_bcd, (c == 4) ? 24'h000000 : 24'h235959);
    end

    // Mid-count exit to edit discards the count; re-entry restarts from 0.
    step();
    step();
    adjust = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("edit_hold_tick_c%0d", c), {23'd0, tick}, 24'd0);
      check($sformatf("edit_hold_time_c%0d", c), time_bcd, 24'h0);
    end
    adjust = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("reentry_tick_c%0d", c), {23'd0, tick}, (c == 4) ? 24'd1 : 24'd0);
      check($sformatf("reentry_time_c%0d", c), time_bcd, (c == 4) ? 24'h000001 : 24'h000000);
    end

    // Reset mid-edit clears all digits and the add history.
    adjust = 1'b0;
    step();
    pulse(4'd0, 3);
    check("midedit_preload", time_bcd, 24'h000004);
    select = 4'd2;
    add = 1'b1;
    rst = 1'b1;
    step();
    check("midedit_rst_time", time_bcd, 24'h0);
    check("midedit_rst_tick", {23'd0, tick}, 24'd0);
    rst = 1'b0;
    step();
    check("post_rst_edge", time_bcd, 24'h000100);
    add = 1'b0;
    step();

`ifdef TIME_CORE_BLINK_EN
    rst = 1'b1;
    adjust = 1'b0;
    select = 4'd3;
    step();
    check("blink_rst", {18'd0, blank}, 24'h0);
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("blink_c%0d", c), {18'd0, blank}, ((c / 2) % 2 == 1) ? 24'h000008 : 24'h0);
    end
    adjust = 1'b1;
    step();
    check("blink_run_off", {18'd0, blank}, 24'h0);
`else
    select = 4'd3;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("blank_off_c%0d", c), {18'd0, blank}, 24'h0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_core.md
# time_core

Timekeeping register file for the DE2 digital clock: holds HH:MM:SS as six BCD digits and advances them once per second while `adjust` is high. It is the consumer of the key-control outputs (`add`, `clr`, `adjust`, `select`). When `adjust` is low, it applies per-digit edits to the digit chosen by `select`. Its BCD bus feeds the seven-segment decode stage.

## Interface
- `TICK_DIV`, default 50_000_000: CLOCK_50 cycles per 1 s tick. Minimum is 2.
- `BLINK_DIV`, default 12_500_000: cycles per blink-phase toggle, giving 2 Hz. Used only with blink compiled in.
- `CLOCK_50` input, 1 bit: single clock. Everything is posedge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `adjust` input, 1 bit: 1 runs the clock, 0 enables edit mode.
- `select` input, 4 bits: digit index for edits.
- `add` input, 1 bit: a rising edge increments the selected digit.
- `clr` input, 1 bit: while high, clears the selected digit (level-sensitive).
- `time_bcd` output, 24 bits: {hr_t, hr_u, min_t, min_u, sec_t, sec_u}, 4 bits each.
- `tick` output, 1 bit: one-cycle pulse on each 1 s advance.
- `blank` output, 6 bits: per-digit blank mask, same bit order as `select` indices.

## Operation
- Digit index map:
  - 0 = sec_u, 1 = sec_t, 2 = min_u, 3 = min_t, 4 = hr_u, 5 = hr_t.
  - Indices 6–15 are ignored: no digit changes.
- Digit ranges:
  - sec_u and min_u: 0–9.
  - sec_t and min_t: 0–5.
  - hr_t: 0–2.
  - hr_u: 0–9 when hr_t < 2, and 0–3 when hr_t = 2.
- Run mode (`adjust` = 1):
  - The prescaler counts 0..TICK_DIV-1. At terminal count it emits `tick` and advances the time.
  - Carry chain is sec_u → sec_t → min_u → min_t → hour.
  - 23:59:59 wraps to 00:00:00.
  - `add` and `clr` are ignored.
- Edit mode (`adjust` = 0):
  - The prescaler is held at 0 and `tick` stays 0.
  - add-edge: the selected digit is incremented, wrapping to 0 at its range maximum. There is no carry into neighbouring digits.
  - If hr_t is incremented to 2 while hr_u > 3, hr_u is forced to 0 in the same cycle.
  - If hr_u is selected with hr_t = 2 and hr_u = 3, hr_u wraps to 0.
  - clr = 1: the selected digit is set to 0 on every cycle that clr is high.
  - clr and add-edge in the same cycle: clr wins and the edge is consumed.
- Edge detect:
  - `add_q` registers `add` every cycle in both modes.
  - add-edge = `add` & ~`add_q`.
  - An `add` held high produces exactly one increment.
- Mode transitions:
  - 1→0: an in-flight prescaler count is discarded.
  - 0→1: the prescaler restarts from 0.
- Reset (`rst` = 1), checked before all else:
  - `time_bcd` = 0, `tick` = 0, `blank` = 0.
  - Prescaler, blink counter and `add_q` are cleared.
  - Reset mid-edit or mid-count discards all state.

## Timing
- All outputs are registered.
- Edits appear on `time_bcd` one cycle after the edge or `clr` sample.
- `tick` is high in the same cycle that `time_bcd` shows the advanced value.
- First tick after reset or after adjust 0→1 arrives TICK_DIV cycles later. Period is exactly TICK_DIV cycles thereafter.
- `select` is sampled in the same cycle as the `add`/`clr` event. There are no setup requirements beyond synchronous inputs.

## Configuration
- `TIME_CORE_BLINK_EN` defined:
  - A blink counter toggles a phase bit every BLINK_DIV cycles while `adjust` = 0.
  - `blank[select]` equals the phase bit for select 0–5. All other `blank` bits are 0.
  - Counter and phase reset to 0 when `adjust` = 1 or `rst`.
- Not defined: `blank` is constant 0 and no blink counter is instantiated.

## Structure
- Package `clock_pkg` holds:
  - digit index constants `DIG_SEC_U` .. `DIG_HR_T`;
  - digit maximum constants (9, 5, 2, 3);
  - a BCD nibble typedef.
- Sub-module `tick_gen`:
  - parameterised modulo-N prescaler with enable and synchronous clear;
  - outputs a terminal-count pulse;
  - instantiated once for the 1 s tick, and once more for blink when enabled.

## Test plan
- **Reset and count-up.** TICK_DIV = 4: assert `rst`, release with `adjust` = 1.
  - `time_bcd` = 0 during reset.
  - `tick` every 4 cycles, first 4 cycles after release.
  - sec_u = 1 after the first tick.
- **Full wrap.** Preload 23:59:59 via edits, set `adjust` = 1.
  - After the next tick, `time_bcd` = 0x000000 and `tick` = 1 for that cycle.
- **Held add and wrap.** `adjust` = 0, select = 1, `add` held high 10 cycles.
  - sec_t increments once only.
  - Pulsing `add` 6 times total returns sec_t to 0, with sec_u and min_u unchanged.
- **Hour clamp.** hr_u = 7, hr_t = 1, select = 5, one `add` pulse.
  - hr_t = 2 and hr_u = 0.
  - Then select = 4 with four pulses gives 1, 2, 3, 0.
- **Conflicts and ignored indices.** clr and an add rising edge in the same cycle on select = 2 with min_u = 4.
  - min_u = 0.
  - select = 9 with `add`/`clr` pulses changes nothing.
- **Mode exit, reset mid-edit, blink.**
  - adjust 0→1: first tick exactly TICK_DIV cycles later.
  - `rst` mid-edit clears all digits.
  - With `TIME_CORE_BLINK_EN`, BLINK_DIV = 2, select = 3, `adjust` = 0: `blank` toggles 6'b001000 ↔ 0 every 2 cycles.
